// File: rtl/digit_scanner.sv
// Digit scanner for a 4-digit 7-segment display: one-hot select, binary index and active-low anodes.
// Define DIGIT_SCANNER_GAP_EN to add anode dead time (GAP_CYCLES clocks) after each digit change.
module digit_scanner #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GAP_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] blank,
  output logic [3:0] sel,
  output logic [3:0] an,
  output logic [1:0] digit_idx,
  output logic       frame_done
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  if (REFRESH_DIV < 2 || GAP_CYCLES < 1 || GAP_CYCLES >= REFRESH_DIV) begin : g_bad_cfg
    $error("digit_scanner: REFRESH_DIV must be >=2 and GAP_CYCLES in [1, REFRESH_DIV)");
  end

  logic [CNT_W-1:0] div_cnt, div_cnt_next;
  logic             tick;
  logic [3:0]       sel_next, an_next;
  logic [1:0]       idx_next;
  logic             frame_done_next;

  // Slot divider and digit rotation; div_cnt restarts so a re-enable gives a full slot.
  always_comb begin
    tick            = enable && (div_cnt == CNT_MAX);
    div_cnt_next    = (!enable || tick) ? '0 : div_cnt + CNT_W'(1);
    sel_next        = tick ? {sel[2:0], sel[3]} : sel;
    idx_next        = tick ? digit_idx + 2'd1 : digit_idx;
    frame_done_next = tick && sel[3];
  end

`ifdef DIGIT_SCANNER_GAP_EN
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic {SCAN, GAP} state_t;

  state_t           state, state_next;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SCAN;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_cnt_next;
    end
  end

  // The tick edge itself is the first dead-time clock, so GAP holds GAP_CYCLES-1 more.
  always_comb begin
    state_next   = state;
    gap_cnt_next = gap_cnt;
    an_next      = ~(sel_next & ~blank);
    if (!enable) begin
      state_next   = SCAN;
      gap_cnt_next = '0;
      an_next      = 4'b1111;
    end else if (tick) begin
      state_next   = GAP;
      gap_cnt_next = '0;
      an_next      = 4'b1111;
    end else if (state == GAP) begin
      if (gap_cnt == GAP_MAX) begin
        state_next   = SCAN;
        gap_cnt_next = '0;
      end else begin
        gap_cnt_next = gap_cnt + GAP_W'(1);
        an_next      = 4'b1111;
      end
    end
  end
`else
  always_comb begin
    an_next = enable ? ~(sel_next & ~blank) : 4'b1111;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      sel        <= 4'b0001;
      digit_idx  <= 2'd0;
      an         <= 4'b1111;
      frame_done <= 1'b0;
    end else begin
      div_cnt    <= div_cnt_next;
      sel        <= sel_next;
      digit_idx  <= idx_next;
      an         <= an_next;
      frame_done <= frame_done_next;
    end
  end

endmodule
